// File: rtl/turn_timer_ctrl_if.sv
// turn_timer_ctrl_if: control pulses in, per-player display and status out.
// master drives the pulses (KEY/SW logic or bench); slave is the controller.
interface turn_timer_ctrl_if;
  logic [2:0] load_mins;
  logic       start;
  logic       swap;
  logic       pause;
  logic       abort;
  logic       active;
  logic [3:0] mins;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       expired;
  logic       loser;
  logic [1:0] state;

  modport master (
    output load_mins, start, swap, pause, abort,
    input  active, mins, tens, ones, running, expired, loser, state
  );

  modport slave (
    input  load_mins, start, swap, pause, abort,
    output active, mins, tens, ones, running, expired, loser, state
  );
endinterface

// File: rtl/turn_timer_ctrl.sv
// turn_timer_ctrl: two-player chess-clock controller sharing one 1 Hz BCD
// countdown. Optional build macro TURN_TIMER_INCREMENT_EN adds INC_SECS to
// the outgoing player's budget on every accepted swap (saturating at 9:59).
module turn_timer_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int INC_SECS = 5
) (
  input logic         CLOCK_50,
  input logic         resetn,
  turn_timer_ctrl_if.slave bus
);
  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, EXPD = 2'd3} st_t;

  // Budgets packed as {mins, tens, ones} BCD per player.
  st_t               st_q, st_d;
  logic [1:0][11:0]  bud_q, bud_d;
  logic              act_q, act_d;
  logic              los_q, los_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tick;

  assign tick = (cnt_q == LAST);

  // One-second BCD decrement; 0:00 stays put (never reached while running).
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] m, t, o;
    m = v[11:8]; t = v[7:4]; o = v[3:0];
    if (o != 4'd0)      o = o - 4'd1;
    else if (t != 4'd0) begin t = t - 4'd1; o = 4'd9; end
    else if (m != 4'd0) begin m = m - 4'd1; t = 4'd5; o = 4'd9; end
    return {m, t, o};
  endfunction

  // Add INC_SECS with BCD carry, saturating at 9:59.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [4:0] o;
    logic [3:0] m, t;
    m = v[11:8]; t = v[7:4];
    o = {1'b0, v[3:0]} + 5'(INC_SECS);
    if (o >= 5'd10) begin o = o - 5'd10; t = t + 4'd1; end
    if (t == 4'd6) begin
      t = 4'd0;
      if (m == 4'd9) return 12'h959;
      m = m + 4'd1;
    end
    return {m, t, o[3:0]};
  endfunction

  // State register: FSM plus budgets, active player, divider and loser.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      st_q  <= IDLE;
      bud_q <= '0;
      act_q <= 1'b0;
      los_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      bud_q <= bud_d;
      act_q <= act_d;
      los_q <= los_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state: abort > start > tick > pause > swap.
  always_comb begin
    st_d  = st_q;
    bud_d = bud_q;
    act_d = act_q;
    los_d = los_q;
    cnt_d = cnt_q;
    if (bus.abort) begin
      st_d  = IDLE;
      act_d = 1'b0;
      cnt_d = '0;
    end else begin
      case (st_q)
        IDLE, EXPD: begin
          if (bus.start && bus.load_mins != 3'd0) begin
            bud_d[0] = {1'b0, bus.load_mins, 8'h00};
            bud_d[1] = {1'b0, bus.load_mins, 8'h00};
            act_d    = 1'b0;
            cnt_d    = '0;
            st_d     = RUN;
          end
        end
        RUN: begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) bud_d[act_q] = bcd_dec(bud_q[act_q]);
          // An expiring tick swallows any same-cycle pause or swap.
          if (tick && bud_d[act_q] == 12'h000) begin
            st_d  = EXPD;
            los_d = act_q;
          end else if (bus.pause) begin
            st_d = PAUSE;
          end else if (bus.swap) begin
`ifdef TURN_TIMER_INCREMENT_EN
            bud_d[act_q] = bcd_inc(bud_d[act_q]);
`endif
            act_d = ~act_q;
            cnt_d = '0;
          end
        end
        PAUSE: begin
          if (bus.pause) st_d = RUN;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // Outputs: active player's digits and state decode, all from registers.
  always_comb begin
    bus.active  = act_q;
    bus.mins    = bud_q[act_q][11:8];
    bus.tens    = bud_q[act_q][7:4];
    bus.ones    = bud_q[act_q][3:0];
    bus.running = (st_q == RUN);
    bus.expired = (st_q == EXPD);
    bus.loser   = los_q;
    bus.state   = st_q;
  end
endmodule

// File: tb/tb_turn_timer_ctrl.sv
// tb_turn_timer_ctrl: table vectors, directed corner sequences and random
// pulses checked against a seconds-based reference model.
module tb_turn_timer_ctrl;
  localparam int TD = 4;
  localparam int INC = 5;
`ifdef TURN_TIMER_INCREMENT_EN
  localparam int INC_ON = 1;
`else
  localparam int INC_ON = 0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  turn_timer_ctrl_if bus();
  turn_timer_ctrl #(.TICK_DIV(TD), .INC_SECS(INC)) dut (
    .CLOCK_50(clk), .resetn(rstn), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: budgets in plain seconds.
  int ms, ma, mcnt, mlos;
  int msec[2];

  task automatic model_reset();
    ms = 0; ma = 0; mcnt = 0; mlos = 0; msec[0] = 0; msec[1] = 0;
  endtask

  task automatic model_step(bit s, bit w, bit p, bit a, bit [2:0] lm);
    bit tk;
    if (a) begin
      ms = 0; ma = 0; mcnt = 0;
    end else if (ms == 0 || ms == 3) begin
      if (s && lm != 0) begin
        msec[0] = lm * 60; msec[1] = lm * 60; ma = 0; mcnt = 0; ms = 1;
      end
    end else if (ms == 1) begin
      tk = (mcnt == TD - 1);
      mcnt = tk ? 0 : mcnt + 1;
      if (tk) msec[ma] = msec[ma] - 1;
      if (tk && msec[ma] == 0) begin
        ms = 3; mlos = ma;
      end else if (p) begin
        ms = 2;
      end else if (w) begin
        if (INC_ON != 0) msec[ma] = (msec[ma] + INC > 599) ? 599 : msec[ma] + INC;
        ma = 1 - ma; mcnt = 0;
      end
    end else begin
      if (p) ms = 1;
    end
  endtask

  function automatic logic [17:0] pack_exp(int st, int act, int sec, int los);
    return {2'(st), 1'(act), 4'(sec / 60), 4'((sec % 60) / 10), 4'(sec % 10),
            st == 1, st == 3, 1'(los)};
  endfunction

  function automatic logic [17:0] obs();
    return {bus.state, bus.active, bus.mins, bus.tens, bus.ones,
            bus.running, bus.expired, bus.loser};
  endfunction

  task automatic chk(string nm, logic [17:0] got, logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d act=%0b %h:%h%h run=%0b exp=%0b los=%0b, want st=%0d act=%0b %h:%h%h run=%0b exp=%0b los=%0b",
               nm, got[17:16], got[15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
               exp[17:16], exp[15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One clock: drive at negedge, model follows the edge, return 1 after it.
  task automatic cyc(bit s, bit w, bit p, bit a, bit [2:0] lm);
    @(negedge clk);
    bus.start = s; bus.swap = w; bus.pause = p; bus.abort = a; bus.load_mins = lm;
    @(posedge clk);
    model_step(s, w, p, a, lm);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 3'd0);
  endtask

  typedef struct {
    bit s, w, p, a;
    bit [2:0] lm;
    int post, es, ea, esec;
    string nm;
  } vec_t;
  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0,  "start_lm0_ignored"};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0, 0, 0,  "idle_swap_pause"};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 0, 1, 0, 60, "start_1_00"};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3, 1, 0, 59, "first_tick"};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 39, 1, 0, 49, "forty_more"};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1, 1, 0, 49, "cnt_to_2"};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 0, 1, 1, 60, "swap_to_p1"};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2, 1, 1, 60, "p1_no_early_tick"};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 1, 1, 59, "p1_tick_at_4"};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 0, 2, 1, 59, "pause"};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 19, 2, 1, 59, "paused_hold"};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 0, 2, 1, 59, "pause_swap_ignored"};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 0, 2, 1, 59, "pause_start_ignored"};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 0, 1, 1, 59, "resume"};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1, 1, 1, 59, "resume_wait"};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 1, 1, 58, "resume_tick"};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 0, 2, 1, 58, "pause_beats_swap"};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 0, 1, 1, 58, "resume2"};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 0, 1, 1, 58, "run_start_ignored"};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0, 0, 49 + 5 * INC_ON, "abort_keeps_budget"};

    bus.start = 0; bus.swap = 0; bus.pause = 0; bus.abort = 0; bus.load_mins = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset_state", obs(), pack_exp(0, 0, 0, 0));
    @(negedge clk) rstn = 1'b1;

    // Table vectors.
    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].w, tbl[i].p, tbl[i].a, tbl[i].lm);
      idle(tbl[i].post);
      chk(tbl[i].nm, obs(), pack_exp(tbl[i].es, tbl[i].ea, tbl[i].esec, 0));
    end

    // Expiry from 0:01 and hold.
    cyc(1, 0, 0, 0, 3'd1); idle(236);
    chk("exp_at_0_01", obs(), pack_exp(1, 0, 1, 0));
    idle(4);
    chk("expire", obs(), pack_exp(3, 0, 0, 0));
    idle(10);
    chk("expired_hold", obs(), pack_exp(3, 0, 0, 0));
    cyc(0, 1, 1, 0, 3'd0);
    chk("expired_ignores", obs(), pack_exp(3, 0, 0, 0));
    cyc(0, 0, 0, 1, 3'd0);
    chk("expired_abort", obs(), pack_exp(0, 0, 0, 0));

    // tick+swap that expires: swap dropped.
    cyc(1, 0, 0, 0, 3'd1); idle(239);
    cyc(0, 1, 0, 0, 3'd0);
    chk("tick_swap_expire", obs(), pack_exp(3, 0, 0, 0));
    cyc(0, 0, 0, 1, 3'd0);

    // tick+swap that does not expire: both apply.
    cyc(1, 0, 0, 0, 3'd1); idle(123);
    cyc(0, 1, 0, 0, 3'd0);
    chk("tick_swap_p1", obs(), pack_exp(1, 1, 60, 0));
    cyc(0, 1, 0, 0, 3'd0);
    chk("tick_swap_p0", obs(), pack_exp(1, 0, 29 + 5 * INC_ON, 0));
    cyc(0, 0, 0, 1, 3'd0);

`ifdef TURN_TIMER_INCREMENT_EN
    cyc(1, 0, 0, 0, 3'd1); idle(12);
    cyc(0, 1, 0, 0, 3'd0); cyc(0, 1, 0, 0, 3'd0);
    chk("inc_0_57", obs(), pack_exp(1, 0, 62, 0));
    cyc(0, 0, 0, 1, 3'd0);
    cyc(1, 0, 0, 0, 3'd7); idle(8);
    chk("inc_6_58", obs(), pack_exp(1, 0, 418, 0));
    for (int k = 0; k < 36; k++) begin cyc(0, 1, 0, 0, 3'd0); cyc(0, 1, 0, 0, 3'd0); end
    chk("inc_9_58", obs(), pack_exp(1, 0, 598, 0));
    cyc(0, 1, 0, 0, 3'd0); cyc(0, 1, 0, 0, 3'd0);
    chk("inc_sat", obs(), pack_exp(1, 0, 599, 0));
    cyc(0, 1, 0, 0, 3'd0); cyc(0, 1, 0, 0, 3'd0);
    chk("inc_sat_hold", obs(), pack_exp(1, 0, 599, 0));
    cyc(0, 0, 0, 1, 3'd0);
`endif

    // Asynchronous reset mid-run.
    cyc(1, 0, 0, 0, 3'd2); idle(7);
    @(negedge clk); rstn = 1'b0; model_reset();
    #1 chk("async_reset", obs(), pack_exp(0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    idle(5);
    chk("after_reset", obs(), pack_exp(0, 0, 0, 0));

    // Random pulses against the model.
    for (int n = 0; n < 6000; n++) begin
      bit s, w, p, a;
      bit [2:0] lm;
      s  = ($urandom_range(99) < 1);
      w  = ($urandom_range(99) < 8);
      p  = ($urandom_range(99) < 4);
      a  = ($urandom_range(999) < 3);
      lm = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd1;
      cyc(s, w, p, a, lm);
      chk("random", obs(), pack_exp(ms, ma, msec[ma], mlos));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
